// File: rtl/mif_arb_pkg.sv
// -----------------------------------------------------------------------------
// mif_arb_pkg
//
// Shared definitions for mif_stream_arbiter and its helpers:
//   - arb_state_e   : arbiter FSM states (IDLE, LOCK)
//   - DEF_*         : stream widths for the default configuration
//   - tdata_width / tkeep_width : stream widths from lane width and lane count
//   - free_entries  : free slots left in the downstream FIFO
// -----------------------------------------------------------------------------
package mif_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_FACTOR     = 4;
  localparam int DEF_TDATA_W    = DEF_DATA_WIDTH * DEF_FACTOR;
  localparam int DEF_TKEEP_W    = DEF_TDATA_W / 8;

  function automatic int tdata_width(input int data_width, input int factor);
    return data_width * factor;
  endfunction

  function automatic int tkeep_width(input int data_width, input int factor);
    return (data_width * factor) / 8;
  endfunction

  // Signed result on purpose: a level above depth reads as "no room".
  function automatic int free_entries(input int level, input int depth);
    return depth - level;
  endfunction

endpackage

// File: rtl/axi4s_if.sv
// -----------------------------------------------------------------------------
// axi4s_if
//
// Minimal AXI4-Stream bundle.
//   aclk   : stream clock (driven by the master side where it is used)
//   tdata  : TDATA_W payload
//   tkeep  : TKEEP_W byte enables
//   tlast  : end of packet
//   tvalid : beat valid (master -> slave)
//   tready : beat accepted (slave -> master)
// Modports: m (master), s (slave).
// -----------------------------------------------------------------------------
interface axi4s_if #(
  parameter int TDATA_W = 256,
  parameter int TKEEP_W = 32
);

  logic               aclk;
  logic [TDATA_W-1:0] tdata;
  logic [TKEEP_W-1:0] tkeep;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport m (output aclk, output tdata, output tkeep, output tlast, output tvalid,
             input tready);

  modport s (input tdata, input tkeep, input tlast, input tvalid,
             output tready);

endinterface

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//
// Purely combinational round-robin pick: scans req_i starting at start_i,
// wrapping modulo N, and reports the first requester found.
//   req_i       : request vector
//   start_i     : index that has highest priority this round
//   grant_oh_o  : one-hot winner (all zero when nothing requests)
//   grant_idx_o : winner index (0 when nothing requests)
//   valid_o     : at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [N-1:0]         grant_oh_o,
  output logic [$clog2(N)-1:0] grant_idx_o,
  output logic                 valid_o
);

  localparam int IDX_W = $clog2(N);

  always_comb begin
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would turn this block into a latch.
    grant_oh_o  = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    idx         = '0;
    for (int off = 0; off < N; off++) begin
      idx = IDX_W'((int'(start_i) + off) % N);
      if (!valid_o && req_i[idx]) begin
        valid_o          = 1'b1;
        grant_idx_o      = idx;
        grant_oh_o[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mif_stream_arbiter.sv
// -----------------------------------------------------------------------------
// mif_stream_arbiter
//
// Packet-granular round-robin arbiter in front of a MultiInsertFIFOAXI slave
// port. A source is granted from its first beat until its tlast handshake, so
// packets never interleave. A new packet starts only if the FIFO has at least
// HEADROOM free entries; once locked, only FIFO tready throttles.
//
// Ports:
//   clk              : single clock
//   rst_n            : synchronous, active-low reset
//   i_src[N]         : requester streams (AXI4S slave side)
//   o_fifo           : stream to the FIFO (AXI4S master side), aclk = clk
//   i_filling_level  : FIFO filling level, sampled only while IDLE
//   o_grant          : current or last granted source index (registered)
//   o_busy           : high while a packet is locked (registered)
//
// Optional build macro MIF_ARB_STATS_EN adds:
//   o_pkt_count[N]   : per-source count of completed packets (wraps at 2^32)
//   o_stall_cycles   : IDLE cycles where a source was valid but headroom
//                      blocked the start of a packet
// -----------------------------------------------------------------------------
module mif_stream_arbiter
  import mif_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int FACTOR      = 4,
  parameter int DEPTH       = 512,
  parameter int HEADROOM    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axi4s_if.s                             i_src [NUM_SOURCES],
  axi4s_if.m                             o_fifo,
  input  logic [$clog2(DEPTH):0]         i_filling_level,
  output logic [$clog2(NUM_SOURCES)-1:0] o_grant,
  output logic                           o_busy
`ifdef MIF_ARB_STATS_EN
  ,
  output logic [31:0]                    o_pkt_count [NUM_SOURCES],
  output logic [31:0]                    o_stall_cycles
`endif
);

  localparam int IDX_W   = $clog2(NUM_SOURCES);
  localparam int TDATA_W = tdata_width(DATA_WIDTH, FACTOR);
  localparam int TKEEP_W = tkeep_width(DATA_WIDTH, FACTOR);

  // Flattened view of the source interfaces so they can be indexed by the
  // registered grant.
  logic [TDATA_W-1:0]     src_tdata [NUM_SOURCES];
  logic [TKEEP_W-1:0]     src_tkeep [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] src_tvalid;
  logic [NUM_SOURCES-1:0] src_tlast;

  arb_state_e             state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic [IDX_W-1:0]       grant_q;
  logic [NUM_SOURCES-1:0] grant_oh_q;
  logic                   busy_q;

  logic [NUM_SOURCES-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   headroom_ok;
  logic                   locked;
  logic                   mux_tvalid;
  logic                   mux_tlast;
  logic                   last_hs;

  // ---------------------------------------------------------------------------
  // Source unpacking and tready fan-out
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    assign src_tdata[g]  = i_src[g].tdata;
    assign src_tkeep[g]  = i_src[g].tkeep;
    assign src_tvalid[g] = i_src[g].tvalid;
    assign src_tlast[g]  = i_src[g].tlast;
    // Only the locked winner sees the FIFO's tready; everyone else is held.
    assign i_src[g].tready = locked & grant_oh_q[g] & o_fifo.tready;
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  rr_priority_picker #(
    .N (NUM_SOURCES)
  ) u_picker (
    .req_i       (src_tvalid),
    .start_i     (rr_ptr_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .valid_o     (pick_valid)
  );

  assign headroom_ok = free_entries(int'(i_filling_level), DEPTH) >= HEADROOM;
  assign locked      = (state_q == LOCK);

  // Pointer moves one past the winner; explicit wrap keeps non-power-of-two
  // source counts correct.
  assign rr_ptr_d = (grant_q == IDX_W'(NUM_SOURCES - 1)) ? '0 : grant_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Data path: single mux, no registers
  // ---------------------------------------------------------------------------
  assign mux_tvalid    = src_tvalid[grant_q];
  assign mux_tlast     = src_tlast[grant_q];
  assign o_fifo.aclk   = clk;
  assign o_fifo.tdata  = src_tdata[grant_q];
  assign o_fifo.tkeep  = src_tkeep[grant_q];
  assign o_fifo.tlast  = mux_tlast;
  assign o_fifo.tvalid = locked & mux_tvalid;

  assign last_hs = locked & mux_tvalid & o_fifo.tready & mux_tlast;

  // ---------------------------------------------------------------------------
  // FSM with registered grant/busy
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid && headroom_ok) begin
            state_q    <= LOCK;
            grant_q    <= pick_idx;
            grant_oh_q <= pick_oh;
            busy_q     <= 1'b1;
          end
        end
        LOCK: begin
          // No headroom re-check and no timeout: only tlast releases the lock.
          if (last_hs) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = busy_q;

`ifdef MIF_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [31:0] pkt_count_q [NUM_SOURCES];
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the counter array is software-visible, so each entry is cleared
      // explicitly rather than left to power-up contents.
      for (int s = 0; s < NUM_SOURCES; s++) begin
        pkt_count_q[s] <= '0;
      end
      stall_q <= '0;
    end else begin
      if (last_hs) begin
        pkt_count_q[grant_q] <= pkt_count_q[grant_q] + 32'd1;
      end
      if (!locked && (|src_tvalid) && !headroom_ok) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_stats
    assign o_pkt_count[g] = pkt_count_q[g];
  end
  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mif_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mif_stream_arbiter
//
// Directed bench for mif_stream_arbiter (4 sources, 64x4 data, DEPTH 512,
// HEADROOM 16). Each source is a simple packet generator whose beats carry
// {source, beat} in tdata[15:0]; FIFO-side handshakes are logged with their
// cycle offset and compared against hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_mif_stream_arbiter;
  import mif_arb_pkg::*;

  localparam int NS      = 4;
  localparam int DEPTH   = 512;
  localparam int HEAD    = 16;
  localparam int TDATA_W = tdata_width(64, 4);
  localparam int TKEEP_W = tkeep_width(64, 4);

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] level;
  logic fifo_tready;
  logic [1:0] grant;
  logic busy;

  logic [TDATA_W-1:0] tb_tdata  [NS];
  logic [TKEEP_W-1:0] tb_tkeep  [NS];
  logic               tb_tvalid [NS];
  logic               tb_tlast  [NS];
  logic               tb_tready [NS];

`ifdef MIF_ARB_STATS_EN
  logic [31:0] pkt_count [NS];
  logic [31:0] stall_cycles;
`endif

  axi4s_if #(.TDATA_W(TDATA_W), .TKEEP_W(TKEEP_W)) src_if [NS] ();
  axi4s_if #(.TDATA_W(TDATA_W), .TKEEP_W(TKEEP_W)) fifo_if ();

  for (genvar g = 0; g < NS; g++) begin : g_drv
    assign src_if[g].aclk   = clk;
    assign src_if[g].tdata  = tb_tdata[g];
    assign src_if[g].tkeep  = tb_tkeep[g];
    assign src_if[g].tvalid = tb_tvalid[g];
    assign src_if[g].tlast  = tb_tlast[g];
    assign tb_tready[g]     = src_if[g].tready;
  end
  assign fifo_if.tready = fifo_tready;

  mif_stream_arbiter #(
    .NUM_SOURCES (NS),
    .DATA_WIDTH  (64),
    .FACTOR      (4),
    .DEPTH       (DEPTH),
    .HEADROOM    (HEAD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_src           (src_if),
    .o_fifo          (fifo_if),
    .i_filling_level (level),
    .o_grant         (grant),
    .o_busy          (busy)
`ifdef MIF_ARB_STATS_EN
    ,
    .o_pkt_count     (pkt_count),
    .o_stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cyc_base = 0;
  int rem  [NS];
  int beat [NS];
  int plen [NS];
  logic [24:0] log_q [$];
  logic [24:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    for (int s = 0; s < NS; s++) begin
      tb_tvalid[s] = rem[s] > 0;
      tb_tlast[s]  = (beat[s] % plen[s]) == plen[s] - 1;
      tb_tdata[s]  = '0;
      tb_tdata[s][15:0] = {8'(s), 8'(beat[s])};
      tb_tkeep[s]  = 32'hFFFF_FFFF >> s;
    end
  endtask

  task automatic clear_src();
    for (int s = 0; s < NS; s++) begin
      rem[s]  = 0;
      beat[s] = 0;
      plen[s] = 1;
    end
  endtask

  task automatic start_test();
    log_q.delete();
    exp_q.delete();
    cyc_base = cyc;
  endtask

  task automatic expect_hs(input int rel, input int src, input int b, input logic last);
    exp_q.push_back({8'(rel), 8'(src), 8'(b), last});
  endtask

  // One clock: sample handshakes mid-cycle, advance generators after the edge.
  task automatic cycle();
    logic hs [NS];
    cyc++;
    @(negedge clk);
    for (int s = 0; s < NS; s++) hs[s] = tb_tvalid[s] && tb_tready[s];
    if (fifo_if.tvalid && fifo_tready)
      log_q.push_back({8'(cyc - cyc_base), fifo_if.tdata[15:8], fifo_if.tdata[7:0], fifo_if.tlast});
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (hs[s]) begin
        rem[s]--;
        beat[s]++;
      end
    end
    apply();
    #1;
  endtask

  task automatic compare_log(input string tag);
    logic [24:0] got;
    check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < log_q.size()) ? log_q[i] : '1;
      check($sformatf("%s[%0d]", tag, i), 64'(got), 64'(exp_q[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    fifo_tready = 1'b1;
    level       = '0;
    clear_src();
    apply();
    repeat (3) cycle();
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fifo_tvalid", 64'(fifo_if.tvalid), 64'd0);
    for (int s = 0; s < NS; s++) check($sformatf("rst_tready%0d", s), 64'(tb_tready[s]), 64'd0);

    // All four sources, two 1-beat packets each: 0,1,2,3,0,1,2,3
    start_test();
    for (int s = 0; s < NS; s++) rem[s] = 2;
    apply();
    #1;
    for (int i = 0; i < 8; i++) expect_hs(2 + 2 * i, i % 4, i / 4, 1'b1);
    repeat (18) cycle();
    compare_log("rr_all");

    // Sources 0 and 2, 3-beat packets: no interleave, one bubble between
    start_test();
    clear_src();
    plen[0] = 3; rem[0] = 3;
    plen[2] = 3; rem[2] = 3;
    apply();
    #1;
    cycle();
    cycle();
    check("p3_grant", 64'(grant), 64'd0);
    check("p3_busy", 64'(busy), 64'd1);
    check("p3_tready0", 64'(tb_tready[0]), 64'd1);
    check("p3_tready2", 64'(tb_tready[2]), 64'd0);
    repeat (8) cycle();
    expect_hs(2, 0, 0, 1'b0); expect_hs(3, 0, 1, 1'b0); expect_hs(4, 0, 2, 1'b1);
    expect_hs(6, 2, 0, 1'b0); expect_hs(7, 2, 1, 1'b0); expect_hs(8, 2, 2, 1'b1);
    compare_log("p3");

    // rr_ptr now 3: source 3 beats source 0, then pointer wraps to 0
    start_test();
    clear_src();
    rem[0] = 1; rem[3] = 1;
    apply();
    #1;
    repeat (6) cycle();
    expect_hs(2, 3, 0, 1'b1); expect_hs(4, 0, 0, 1'b1);
    compare_log("wrap");

    // Headroom: free = 15 blocks, free = 16 admits
    start_test();
    clear_src();
    level = 10'(DEPTH - HEAD + 1);
    rem[1] = 1;
    apply();
    #1;
    repeat (3) cycle();
    check("hr_busy", 64'(busy), 64'd0);
    check("hr_tready1", 64'(tb_tready[1]), 64'd0);
    check("hr_fifo_tvalid", 64'(fifo_if.tvalid), 64'd0);
    check("hr_last_grant", 64'(grant), 64'd0);
    level = 10'(DEPTH - HEAD);
    cycle();
    check("hr_go_grant", 64'(grant), 64'd1);
    check("hr_go_busy", 64'(busy), 64'd1);
    check("hr_go_tvalid", 64'(fifo_if.tvalid), 64'd1);
    cycle();
    cycle();
    check("hr_done_busy", 64'(busy), 64'd0);
    level = '0;

    // FIFO backpressure mid-packet for 5 cycles
    start_test();
    clear_src();
    plen[2] = 4; rem[2] = 4;
    rem[0] = 1;
    apply();
    #1;
    cycle();
    cycle();
    check("bp_tready2", 64'(tb_tready[2]), 64'd1);
    check("bp_tready0", 64'(tb_tready[0]), 64'd0);
    fifo_tready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_tdata", 64'(fifo_if.tdata[15:0]), 64'h0201);
      check("bp_tkeep", 64'(fifo_if.tkeep), 64'h3FFF_FFFF);
      check("bp_tvalid", 64'(fifo_if.tvalid), 64'd1);
      check("bp_grant", 64'(grant), 64'd2);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_src_tready0", 64'(tb_tready[0]), 64'd0);
      check("bp_src_tready2", 64'(tb_tready[2]), 64'd0);
    end
    fifo_tready = 1'b1;
    #1;
    repeat (6) cycle();
    expect_hs(2, 2, 0, 1'b0); expect_hs(8, 2, 1, 1'b0); expect_hs(9, 2, 2, 1'b0);
    expect_hs(10, 2, 3, 1'b1); expect_hs(12, 0, 0, 1'b1);
    compare_log("bp");

    // Reset for one cycle after two beats of a 4-beat packet
    start_test();
    clear_src();
    plen[1] = 4; rem[1] = 4;
    apply();
    #1;
    repeat (3) cycle();
    check("mr_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    check("mr_grant", 64'(grant), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_fifo_tvalid", 64'(fifo_if.tvalid), 64'd0);
    check("mr_tready1", 64'(tb_tready[1]), 64'd0);
    clear_src();
    apply();
    #1;
    repeat (2) cycle();

`ifdef MIF_ARB_STATS_EN
    // Statistics: counters were cleared by the reset above
    clear_src();
    rem[3] = 3;
    apply();
    #1;
    repeat (8) cycle();
    check("st_pkt3", 64'(pkt_count[3]), 64'd3);
    check("st_pkt0", 64'(pkt_count[0]), 64'd0);
    level = 10'(DEPTH - HEAD + 1);
    rem[0] = 1;
    apply();
    #1;
    repeat (7) cycle();
    check("st_stall", 64'(stall_cycles), 64'd7);
    clear_src();
    apply();
    level = '0;
    #1;
    cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
